// File: rtl/serial_mac_tag.sv
// serial_mac_tag: bit-serial tag generator for the ECC/MAC datapath.
// Computes a W-bit tag Y from operand X and key word R in one pass of W/B
// cycles. The pass carries a running prefix XOR of X&R from group to group.
// A valid/ready input accepts one job at a time. The tag is held until a
// valid/ready output handshake takes it.
// Optional feature macro: SERIAL_MAC_TAG_PARITY_EN adds port tag_par (= ^y).
`timescale 1ns/1ps

module serial_mac_tag #(
  parameter int W = 32,
  parameter int B = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] r,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SERIAL_MAC_TAG_PARITY_EN
  output logic         tag_par,
`endif
  output logic [W-1:0] y
);

  // idx must reach W itself, so it is one bit wider than a bit index.
  localparam int IW = $clog2(W + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  y_q, y_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          p_q, p_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
`ifdef SERIAL_MAC_TAG_PARITY_EN
  logic          tag_par_q, tag_par_d;
`endif

  // Per-bit terms of the tag formula, precomputed from the latched operands.
  // The neighbour products are shifted so that bit 0 sees zero and never
  // needs a bit -1. xr_s has bit 0 masked because the prefix starts at j=1.
  logic [W-1:0]  xx_s;
  logic [W-1:0]  rr_s;
  logic [W-1:0]  xr_s;
  logic          c0_s;
  logic          p_acc_s;
  logic [BW-1:0] bidx_s;

  assign xx_s = x_q & {x_q[W-2:0], 1'b0};
  assign rr_s = r_q & {r_q[W-2:0], 1'b0};
  assign xr_s = {x_q[W-1:1] & r_q[W-1:1], 1'b0};
  assign c0_s = x_q[0] & r_q[0];

  // Next-state logic: job accept, one B-bit tag group per RUN cycle, and the
  // output handshake.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    r_d         = r_q;
    y_d         = y_q;
    idx_d       = idx_q;
    p_d         = p_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    p_acc_s     = p_q;
    bidx_s      = {BW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = x;
          r_d        = r;
          y_d        = {W{1'b0}};
          idx_d      = {IW{1'b0}};
          p_d        = 1'b0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Bits ascend within the group. The prefix XOR picks up bit i only
        // after bit i has been computed.
        for (int k = 0; k < B; k++) begin
          bidx_s      = idx_q[BW-1:0] + BW'(k);
          y_d[bidx_s] = c0_s ^ xx_s[bidx_s] ^ rr_s[bidx_s] ^ p_acc_s;
          p_acc_s     = p_acc_s ^ xr_s[bidx_s];
        end
        p_d   = p_acc_s;
        idx_d = idx_q + IW'(B);
        if (idx_d == IW'(W)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        y_d         = {W{1'b0}};
        idx_d       = {IW{1'b0}};
        p_d         = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

`ifdef SERIAL_MAC_TAG_PARITY_EN
  // Parity follows every y write, so it is already valid when DONE is entered.
  always_comb begin
    tag_par_d = ^y_d;
  end
`endif

  // State and output registers; synchronous reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= {W{1'b0}};
      r_q         <= {W{1'b0}};
      y_q         <= {W{1'b0}};
      idx_q       <= {IW{1'b0}};
      p_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_MAC_TAG_PARITY_EN
      tag_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      r_q         <= r_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_MAC_TAG_PARITY_EN
      tag_par_q   <= tag_par_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
`ifdef SERIAL_MAC_TAG_PARITY_EN
  assign tag_par   = tag_par_q;
`endif

endmodule

// File: tb/tb_serial_mac_tag.sv
// Directed/self-checking bench for serial_mac_tag: three instances
// (W=4/B=1, W=4/B=2, W=32/B=1) driven from one linear initial block.
`timescale 1ns/1ps

module tb_serial_mac_tag;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: W=4, B=1
  logic       a_iv, a_ir, a_busy, a_ov, a_ordy, a_par;
  logic [3:0] a_x, a_r, a_y;
  // Instance B: W=4, B=2
  logic       b_iv, b_ir, b_busy, b_ov, b_ordy, b_par;
  logic [3:0] b_x, b_r, b_y;
  // Instance C: W=32, B=1
  logic        c_iv, c_ir, c_busy, c_ov, c_ordy, c_par;
  logic [31:0] c_x, c_r, c_y;

  int tests = 0;
  int fails = 0;

  serial_mac_tag #(.W(4), .B(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .r(a_r),
    .busy(a_busy), .out_valid(a_ov), .out_ready(a_ordy),
`ifdef SERIAL_MAC_TAG_PARITY_EN
    .tag_par(a_par),
`endif
    .y(a_y));

  serial_mac_tag #(.W(4), .B(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .r(b_r),
    .busy(b_busy), .out_valid(b_ov), .out_ready(b_ordy),
`ifdef SERIAL_MAC_TAG_PARITY_EN
    .tag_par(b_par),
`endif
    .y(b_y));

  serial_mac_tag #(.W(32), .B(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .x(c_x), .r(c_r),
    .busy(c_busy), .out_valid(c_ov), .out_ready(c_ordy),
`ifdef SERIAL_MAC_TAG_PARITY_EN
    .tag_par(c_par),
`endif
    .y(c_y));

`ifndef SERIAL_MAC_TAG_PARITY_EN
  assign a_par = 1'b0;
  assign b_par = 1'b0;
  assign c_par = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference tag: direct evaluation of the formula, prefix XOR re-summed per bit.
  function automatic logic [31:0] model32(input logic [31:0] xv, input logic [31:0] rv);
    logic        c0, p;
    logic [31:0] yv;
    c0    = xv[0] & rv[0];
    yv    = 32'd0;
    yv[0] = c0;
    for (int i = 1; i < 32; i++) begin
      p = 1'b0;
      for (int j = 1; j < i; j++) p = p ^ (xv[j] & rv[j]);
      yv[i] = c0 ^ (xv[i] & xv[i-1]) ^ (rv[i] & rv[i-1]) ^ p;
    end
    return yv;
  endfunction

  // One W=32 job: operands are scrambled right after accept, busy length,
  // tag, a random consumer stall, and the return to IDLE are all checked.
  task automatic job32(input logic [31:0] xv, input logic [31:0] rv, input int hold, input string tag);
    int n;
    logic [31:0] exp_y;
    exp_y = model32(xv, rv);
    c_x = xv; c_r = rv; c_iv = 1'b1;
    tick;
    c_iv = 1'b0;
    c_x = $urandom; c_r = $urandom;
    n = 0;
    while (c_busy && n < 100) begin
      n++;
      tick;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'd32);
    chk({tag, " out_valid"}, {31'd0, c_ov}, 32'd1);
    chk({tag, " y"}, c_y, exp_y);
`ifdef SERIAL_MAC_TAG_PARITY_EN
    chk({tag, " tag_par"}, {31'd0, c_par}, {31'd0, ^exp_y});
`endif
    for (int k = 0; k < hold; k++) tick;
    chk({tag, " y_held"}, c_y, exp_y);
    c_ordy = 1'b1;
    tick;
    c_ordy = 1'b0;
    chk({tag, " in_ready_after"}, {31'd0, c_ir}, 32'd1);
    chk({tag, " out_valid_after"}, {31'd0, c_ov}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1;
    a_iv = 1'b0; a_ordy = 1'b0; a_x = 4'd0; a_r = 4'd0;
    b_iv = 1'b0; b_ordy = 1'b0; b_x = 4'd0; b_r = 4'd0;
    c_iv = 1'b0; c_ordy = 1'b0; c_x = 32'd0; c_r = 32'd0;
    tick;
    tick;
    // Reset state
    chk("rst c in_ready", {31'd0, c_ir}, 32'd1);
    chk("rst c busy", {31'd0, c_busy}, 32'd0);
    chk("rst c out_valid", {31'd0, c_ov}, 32'd0);
    chk("rst c y", c_y, 32'd0);
    chk("rst a in_ready", {31'd0, a_ir}, 32'd1);
`ifdef SERIAL_MAC_TAG_PARITY_EN
    chk("rst c tag_par", {31'd0, c_par}, 32'd0);
`endif
    reset = 1'b0;
    tick;

    // W=4, B=1: x=0011, r=0101 -> y=D after 4 cycles
    a_x = 4'b0011; a_r = 4'b0101; a_iv = 1'b1;
    tick;
    a_iv = 1'b0;
    chk("a busy", {31'd0, a_busy}, 32'd1);
    chk("a in_ready low", {31'd0, a_ir}, 32'd0);
    n = 0;
    while (!a_ov && n < 20) begin
      tick;
      n++;
    end
    chk("a latency", 32'(n), 32'd4);
    chk("a y", {28'd0, a_y}, 32'hD);
`ifdef SERIAL_MAC_TAG_PARITY_EN
    chk("a tag_par", {31'd0, a_par}, 32'd1);
`endif
    a_ordy = 1'b1;
    tick;
    a_ordy = 1'b0;
    chk("a in_ready back", {31'd0, a_ir}, 32'd1);

    // W=4, B=2: x=F, r=F -> y=B after 2 RUN cycles
    b_x = 4'hF; b_r = 4'hF; b_iv = 1'b1;
    tick;
    b_iv = 1'b0;
    n = 0;
    while (!b_ov && n < 20) begin
      tick;
      n++;
    end
    chk("b latency", 32'(n), 32'd2);
    chk("b y FF", {28'd0, b_y}, 32'hB);
    b_ordy = 1'b1;
    tick;
    b_ordy = 1'b0;
    // x=0, r=0 with out_ready held high from before the accept
    b_ordy = 1'b1;
    b_x = 4'h0; b_r = 4'h0; b_iv = 1'b1;
    tick;
    b_iv = 1'b0;
    n = 0;
    while (!b_ov && n < 20) begin
      tick;
      n++;
    end
    chk("b latency2", 32'(n), 32'd2);
    chk("b y 00", {28'd0, b_y}, 32'h0);
    tick;
    chk("b done one cycle", {31'd0, b_ov}, 32'd0);
    chk("b in_ready", {31'd0, b_ir}, 32'd1);
    b_ordy = 1'b0;

    // Handshake: in_valid held through RUN and DONE is ignored
    c_x = 32'h1234_5678; c_r = 32'h9ABC_DEF0; c_iv = 1'b1;
    tick;
    n = 0;
    while (c_busy && n < 100) begin
      if (c_ir) n = 200;
      else n++;
      tick;
    end
    chk("hs run cycles", 32'(n), 32'd32);
    chk("hs out_valid", {31'd0, c_ov}, 32'd1);
    tick;
    tick;
    chk("hs in_ready in done", {31'd0, c_ir}, 32'd0);
    chk("hs still done", {31'd0, c_ov}, 32'd1);
    chk("hs y", c_y, model32(32'h1234_5678, 32'h9ABC_DEF0));
    c_iv = 1'b0;
    c_ordy = 1'b1;
    tick;
    c_ordy = 1'b0;
    chk("hs in_ready after", {31'd0, c_ir}, 32'd1);
    tick;
    chk("hs no queued job", {31'd0, c_busy}, 32'd0);

    // Reset mid-RUN at idx=2
    c_x = 32'hFFFF_FFFF; c_r = 32'hFFFF_FFFF; c_iv = 1'b1;
    tick;
    c_iv = 1'b0;
    tick;
    tick;
    chk("mid y partial", c_y, 32'h0000_0003);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid rst in_ready", {31'd0, c_ir}, 32'd1);
    chk("mid rst busy", {31'd0, c_busy}, 32'd0);
    chk("mid rst out_valid", {31'd0, c_ov}, 32'd0);
    chk("mid rst y", c_y, 32'd0);
    job32(32'hDEAD_BEEF, 32'hCAFE_F00D, 1, "after rst");

    // Directed corner operands
    job32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "ones");
    job32(32'h0000_0000, 32'h0000_0000, 0, "zeros");

    // Random jobs with random consumer stall
    for (int t = 0; t < 200; t++) begin
      job32($urandom, $urandom, $urandom_range(0, 5), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
